adc_frame_rx: RTL
=================

Name: adc_frame_rx

Overview:
- Serial ADC front end. Sits directly upstream of the compression stage and the compression-path mux; it supplies the 16-bit adc sample word.
- On each sample tick (the adc_clock rate, delivered as a one-cycle pulse in the clk domain), it drives chip-select and a mode-0 serial clock to the external ADC and shifts in one MSB-first frame on miso.
- Captured words are buffered in a small FIFO and delivered over a valid/ready handshake.
- Flags dropped ticks and dropped samples.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period; must be >= 3.
- FRAME_BITS, 16: bits shifted per frame.
- DATA_W, 16: output sample width; must equal FRAME_BITS.
- FIFO_DEPTH, 4: output buffer entries; power of two.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low aborts any frame in progress.
- sample_tick  in  1  one-cycle frame start request.
- clear_flags  in  1  one-cycle pulse; clears overrun.
- miso  in  1  ADC serial data; asynchronous to clk.
- sclk  out  1  serial clock to ADC; idles low.
- cs_n  out  1  ADC chip select; active low.
- out_data  out  DATA_W  FIFO head sample, two's complement.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word this cycle.
- busy  out  1  frame in progress (state != IDLE).
- overrun  out  1  sticky error flag.

Behaviour:
- Reset values: sclk=0, cs_n=1, out_data=0, out_valid=0, busy=0, overrun=0. FIFO empty, state IDLE, counters 0. All registers reset asynchronously on rst_n low.
- miso passes through a 2-flop synchronizer before use.
- FSM states and transitions:
  - IDLE: sclk=0, cs_n=1. If enable=1 and sample_tick=1, go to START next cycle.
  - START: cs_n=0, sclk=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: cs_n=0. sclk toggles every CLK_DIV cycles, low phase first, for FRAME_BITS full periods (2*CLK_DIV*FRAME_BITS cycles).
    - On the last clk cycle of each sclk high phase, shift the synchronized miso into the LSB of the shift register. First bit captured is the MSB.
  - STOP: one cycle, cs_n=1, sclk=0. Push the shift register into the FIFO. Go to IDLE.
- Latency from accepted tick (cycle 0) to out_valid (FIFO previously empty): 2 + CLK_DIV*(2*FRAME_BITS+1) cycles. With defaults this is 134 cycles.
- Handshake:
  - A word pops when out_valid && out_ready.
  - out_data always shows the FIFO head, and holds its value when not popped.
  - out_valid is registered and updates the cycle after a push or pop.
- Overrun is set (and stays set until clear_flags or reset) by either of:
  - sample_tick arriving while busy=1; the tick is ignored and the frame in progress is unaffected.
  - A STOP push with the FIFO full and no pop in the same cycle; the new sample is dropped and FIFO contents are unchanged.
- Simultaneous push and pop when full: both succeed, and the FIFO stays full. Push and pop when empty: no bypass; out_valid rises the next cycle.
- clear_flags and a set event in the same cycle: the set wins.
- enable deasserted mid-frame:
  - Next cycle: state=IDLE, cs_n=1, sclk=0, busy=0.
  - The partial word is discarded and nothing is pushed.
  - FIFO contents are retained and stay poppable.
- sample_tick with enable=0: ignored, and overrun is not set.
- FIFO pointers carry one extra wrap bit. Full = indices equal and wrap bits differ. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, SHIFT, STOP) and default widths DATA_W=16, FRAME_BITS=16.
- One sub-module: sync_fifo (parameters DATA_W and FIFO_DEPTH; ports push, pop, din, dout, empty, full).
- Synchronizer, bit/phase counters and FSM stay in adc_frame_rx.

Test Plan:
1. Reset then single frame: rst_n low→high, enable=1, drive the ADC model with 0xA5C3, one tick, out_ready=1 → cs_n low for exactly 132 cycles, 16 sclk rising edges, out_valid=1 at cycle 134 with out_data=0xA5C3, popped in one cycle; overrun=0.
2. Back-pressure fill: out_ready=0, five frames of 0x0001..0x0005 → after frame 4, out_valid=1 and head=0x0001. Frame 5 is dropped and overrun=1. Draining yields 0x0001..0x0004 in order, then out_valid=0.
3. Tick while busy: second tick 50 cycles after the first → one frame only (16 sclk edges), overrun=1. A clear_flags pulse then returns overrun to 0.
4. Abort: drop enable at cycle 70 of a frame → the next cycle shows cs_n=1, sclk=0, busy=0. Nothing is pushed; a previously buffered 0x1234 is still at the head.
5. Full with concurrent pop: FIFO full, out_ready=1 in the STOP cycle of 0x7FFF → no overrun, FIFO stays full, 0x7FFF is last in drain order.
6. Async reset mid-frame: rst_n low during SHIFT → all outputs are at reset values immediately (without waiting for a clk edge) and the FIFO is empty. Normal frames resume after release.

Source files
------------

// File: rtl/adc_frame_rx_pkg.sv
// Shared definitions for the serial ADC frame receiver:
// FSM state encoding and default frame/sample widths.
package adc_frame_rx_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int FRAME_BITS_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/adc_frame_rx_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head word is always
// presented on dout. Push while full only lands when a pop frees a slot.
module sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_q, rd_q;
    logic              do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_frame_rx.sv
// Serial ADC front end: mode-0 frame capture on each sample tick,
// buffered output over valid/ready, sticky overrun on dropped ticks/samples.
module adc_frame_rx
    import adc_frame_rx_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic              clear_flags,
    input  logic              miso,
    output logic              sclk,
    output logic              cs_n,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = $clog2(2 * FRAME_BITS);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [HW-1:0]         half_q, half_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  sync1_q, sync2_q;
    logic                  overrun_q, overrun_d;
    logic                  push, pop, empty, full;
    logic                  last_phase, last_half;

    assign last_phase = (cnt_q == CW'(CLK_DIV - 1));
    assign last_half  = (half_q == HW'(2 * FRAME_BITS - 1));

    assign busy      = (state_q != ST_IDLE);
    assign cs_n      = !((state_q == ST_START) || (state_q == ST_SHIFT));
    // Odd half-periods are the high phase, so the first half is low.
    assign sclk      = (state_q == ST_SHIFT) && half_q[0];
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign overrun   = overrun_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && sample_tick) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (last_phase) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    half_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_phase) begin
                    cnt_d = '0;
                    if (half_q[0]) begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], sync2_q};
                    end
                    if (last_half) begin
                        state_d = ST_STOP;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
            push    = 1'b0;
        end
    end

    // A set event takes priority over a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (clear_flags) begin
            overrun_d = 1'b0;
        end
        if ((sample_tick && enable && busy) || (push && full && !pop)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            half_q    <= '0;
            shreg_q   <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            sync1_q   <= miso;
            sync2_q   <= sync1_q;
            overrun_q <= overrun_d;
        end
    end

    sync_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (shreg_q),
        .dout (out_data),
        .empty(empty),
        .full (full)
    );

endmodule
